kf_spike_capture: RTL and testbench

- Downstream capture stage for the 2x2 Kitten Fabric mesh.
- Sinks the mesh's external spike output stream (valid/ready/spike_flit_t).
- Tags each accepted flit with a capture-relative timestamp and buffers the pair in a FIFO that the host/testbench drains.
- Arm/stop/clear control, bounded capture window and limit, drop accounting.

---
 rtl/kf_spike_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_kf_spike_capture.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_spike_capture.sv
// Spike capture stage for the 2x2 Kitten Fabric mesh.
// Sinks the mesh's external spike output stream, tags each accepted flit with a
// capture-relative timestamp and queues {ts, flit} in a FIFO that the host drains.
// Arm/stop/clear control, an optional capture window and flit limit, and
// saturating drop accounting.
//
// FLIT_W must equal $bits(spike_flit_t) of the mesh. The flit is carried as an
// opaque vector so this file stands alone.

module kf_spike_capture #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned TS_W         = 16,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLIT_W       = 16,
    parameter bit          DROP_ON_FULL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // Mesh output stream
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FLIT_W-1:0]        in_flit,
    // Control and configuration
    input  logic                     ctl_arm,
    input  logic                     ctl_stop,
    input  logic                     ctl_clear,
    input  logic [TS_W-1:0]          cfg_window,
    input  logic [CNT_W-1:0]         cfg_limit,
    // Host read port
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [FLIT_W-1:0]        rd_flit,
    output logic [TS_W-1:0]          rd_ts,
    // Status
    output logic [1:0]               state_o,
    output logic [CNT_W-1:0]         captured_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     done_pulse
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned ENTRY_W = TS_W + FLIT_W;

    typedef enum logic [1:0] {
        StDisarmed  = 2'd0,
        StArmed     = 2'd1,
        StCapturing = 2'd2,
        StDone      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               done_pulse_q, done_pulse_d;

    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;

    logic               cap_st;
    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic [CNT_W-1:0]   cap_next;
    logic [CNT_W-1:0]   drop_next;
    logic               window_hit;
    logic               limit_hit;

    // Handshake and FIFO strobes; full/empty come only from registered occupancy
    always_comb begin
        cap_st = (state_q == StArmed) || (state_q == StCapturing);
        full   = (level_q == LW'(DEPTH));
        empty  = (level_q == '0);
        if (DROP_ON_FULL) begin
            in_ready = 1'b1;
        end else begin
            in_ready = !(cap_st && full);
        end
        accept = in_valid && in_ready;
        // A clear in the same cycle wins over any push, drop or pop
        push   = accept && cap_st && !full && !ctl_clear;
        drop   = accept && cap_st && full && !ctl_clear;
        pop    = !empty && rd_ready && !ctl_clear;
    end

    // Saturating counter increments and end-of-capture conditions
    always_comb begin
        cap_next  = cap_cnt_q;
        drop_next = drop_cnt_q;
        if (push && (cap_cnt_q != '1)) begin
            cap_next = cap_cnt_q + CNT_W'(1);
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_next = drop_cnt_q + CNT_W'(1);
        end
        window_hit = (cfg_window != '0) && (ts_q == cfg_window - TS_W'(1));
        limit_hit  = (cfg_limit != '0) && push && (cap_next == cfg_limit);
    end

    // Capture FSM next state, timestamp and counters; clear > stop > arm
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        cap_cnt_d  = cap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (ctl_clear) begin
            state_d    = StDisarmed;
            ts_d       = '0;
            cap_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            unique case (state_q)
                StDisarmed, StDone: begin
                    // Stop outranks arm even though it has nothing to stop here
                    if (ctl_arm && !ctl_stop) begin
                        state_d    = StArmed;
                        ts_d       = '0;
                        cap_cnt_d  = '0;
                        drop_cnt_d = '0;
                    end
                end
                StArmed: begin
                    cap_cnt_d  = cap_next;
                    drop_cnt_d = drop_next;
                    if (ctl_stop) begin
                        state_d = StDone;
                    end else if (accept) begin
                        // The first accepted flit (stored or dropped) is capture cycle 0
                        ts_d = ts_q + TS_W'(1);
                        if (window_hit || limit_hit) begin
                            state_d = StDone;
                        end else begin
                            state_d = StCapturing;
                        end
                    end
                end
                StCapturing: begin
                    cap_cnt_d  = cap_next;
                    drop_cnt_d = drop_next;
                    ts_d       = ts_q + TS_W'(1);
                    if (ctl_stop || window_hit || limit_hit) begin
                        state_d = StDone;
                    end
                end
                default: begin
                    state_d = StDisarmed;
                end
            endcase
        end
        done_pulse_d = (state_d == StDone) && (state_q != StDone);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StDisarmed;
            ts_q         <= '0;
            cap_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            cap_cnt_q    <= cap_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (ctl_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, in_flit};
        end
    end

    // Head of FIFO and status outputs
    always_comb begin
        head           = mem_q[rd_ptr_q];
        rd_valid       = !empty;
        rd_flit        = head[FLIT_W-1:0];
        rd_ts          = head[FLIT_W +: TS_W];
        state_o        = state_q;
        captured_count = cap_cnt_q;
        drop_count     = drop_cnt_q;
        fifo_level     = level_q;
        done_pulse     = done_pulse_q;
    end

endmodule

// File: tb/tb_kf_spike_capture.sv
// Directed bench for kf_spike_capture. Instance a drops on full, instance b
// backpressures; both share clock, reset, control and configuration.

module tb_kf_spike_capture;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FLIT_W = 16;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              ctl_arm, ctl_stop, ctl_clear;
    logic [TS_W-1:0]   cfg_window;
    logic [CNT_W-1:0]  cfg_limit;

    logic              a_in_valid, a_in_ready, a_rd_valid, a_rd_ready, a_done;
    logic [FLIT_W-1:0] a_in_flit, a_rd_flit;
    logic [TS_W-1:0]   a_rd_ts;
    logic [1:0]        a_state;
    logic [CNT_W-1:0]  a_cap, a_drop;
    logic [LVL_W-1:0]  a_level;

    logic              b_in_valid, b_in_ready, b_rd_valid, b_rd_ready, b_done;
    logic [FLIT_W-1:0] b_in_flit, b_rd_flit;
    logic [TS_W-1:0]   b_rd_ts;
    logic [1:0]        b_state;
    logic [CNT_W-1:0]  b_cap, b_drop;
    logic [LVL_W-1:0]  b_level;

    kf_spike_capture #(
        .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .FLIT_W(FLIT_W), .DROP_ON_FULL(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_flit(a_in_flit),
        .ctl_arm(ctl_arm), .ctl_stop(ctl_stop), .ctl_clear(ctl_clear),
        .cfg_window(cfg_window), .cfg_limit(cfg_limit),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_flit(a_rd_flit), .rd_ts(a_rd_ts),
        .state_o(a_state), .captured_count(a_cap), .drop_count(a_drop),
        .fifo_level(a_level), .done_pulse(a_done)
    );

    kf_spike_capture #(
        .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .FLIT_W(FLIT_W), .DROP_ON_FULL(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_flit(b_in_flit),
        .ctl_arm(ctl_arm), .ctl_stop(ctl_stop), .ctl_clear(ctl_clear),
        .cfg_window(cfg_window), .cfg_limit(cfg_limit),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_flit(b_rd_flit), .rd_ts(b_rd_ts),
        .state_o(b_state), .captured_count(b_cap), .drop_count(b_drop),
        .fifo_level(b_level), .done_pulse(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        ctl_clear = 1'b1;
        tick();
        ctl_clear = 1'b0;
    endtask

    task automatic pulse_arm();
        ctl_arm = 1'b1;
        tick();
        ctl_arm = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, pulse_at, sent, got, order_err, ts_err, prev_ts, ready_low;
        logic acc, pop;
        int exp_ts [3];
        exp_ts = '{0, 4, 9};

        rst_n      = 1'b0;
        ctl_arm    = 1'b0;
        ctl_stop   = 1'b0;
        ctl_clear  = 1'b0;
        cfg_window = '0;
        cfg_limit  = '0;
        a_in_valid = 1'b0; a_in_flit = '0; a_rd_ready = 1'b0;
        b_in_valid = 1'b0; b_in_flit = '0; b_rd_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_state", a_state, 0);
        check_eq("rst_level", a_level, 0);
        check_eq("rst_rd_valid", a_rd_valid, 0);
        check_eq("rst_in_ready", a_in_ready, 1);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_cap", a_cap, 0);
        check_eq("rst_drop", a_drop, 0);
        check_eq("rst_b_in_ready", b_in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Unbounded capture: 5 consecutive flits get ts 0..4
        pulse_arm();
        check_eq("t1_armed", a_state, 1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_flit  = 16'h0100 + 16'(i);
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("t1_level", a_level, 5);
        check_eq("t1_cap", a_cap, 5);
        check_eq("t1_state", a_state, 2);
        for (int i = 0; i < 5; i++) begin
            check_eq("t1_flit", a_rd_flit, 32'h100 + i);
            check_eq("t1_ts", a_rd_ts, i);
            a_rd_ready = 1'b1;
            tick();
        end
        a_rd_ready = 1'b0;
        check_eq("t1_level_drained", a_level, 0);
        check_eq("t1_cap_after_pop", a_cap, 5);

        // Window of 10: flits at capture cycles 0,4,9,12
        pulse_clear();
        check_eq("t2_cleared", a_state, 0);
        cfg_window = 16'd10;
        pulse_arm();
        a_in_valid = 1'b1;
        a_in_flit  = 16'h0200;
        tick();
        a_in_valid = 1'b0;
        pulses   = 0;
        pulse_at = -1;
        for (int c = 1; c <= 14; c++) begin
            if (a_done) begin
                pulses++;
                pulse_at = c;
            end
            if (c == 9) check_eq("t2_state_c9", a_state, 2);
            if (c == 10) check_eq("t2_state_c10", a_state, 3);
            a_in_valid = (c == 4) || (c == 9) || (c == 12);
            a_in_flit  = 16'h0200 + 16'(c);
            if (c == 12) check_eq("t2_ready_done", a_in_ready, 1);
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("t2_pulses", pulses, 1);
        check_eq("t2_pulse_at", pulse_at, 10);
        check_eq("t2_level", a_level, 3);
        check_eq("t2_cap", a_cap, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_ts", a_rd_ts, exp_ts[i]);
            check_eq("t2_flit", a_rd_flit, 32'h200 + exp_ts[i]);
            a_rd_ready = 1'b1;
            tick();
        end
        a_rd_ready = 1'b0;

        // Drop-on-full: 70 back-to-back flits into instance a
        pulse_clear();
        cfg_window = '0;
        cfg_limit  = '0;
        pulse_arm();
        ready_low = 0;
        for (int i = 0; i < 70; i++) begin
            a_in_valid = 1'b1;
            a_in_flit  = 16'(i);
            if (!a_in_ready) ready_low++;
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("t3_ready_low", ready_low, 0);
        check_eq("t3_level", a_level, 64);
        check_eq("t3_cap", a_cap, 64);
        check_eq("t3_drop", a_drop, 6);
        check_eq("t3_head_flit", a_rd_flit, 0);

        // Backpressure: instance b, same 70 flits, pops every other cycle
        check_eq("t4_b_armed", b_state, 1);
        sent = 0;
        for (int cyc = 0; cyc < 200 && b_in_ready; cyc++) begin
            b_in_valid = 1'b1;
            b_in_flit  = 16'(sent);
            tick();
            sent++;
        end
        b_in_flit = 16'(sent);
        check_eq("t4_ready_full", b_in_ready, 0);
        check_eq("t4_sent_full", sent, 64);
        check_eq("t4_level_full", b_level, 64);
        got       = 0;
        order_err = 0;
        ts_err    = 0;
        prev_ts   = -1;
        for (int cyc = 0; cyc < 1000 && got < 70; cyc++) begin
            b_in_valid = (sent < 70);
            b_in_flit  = 16'(sent);
            acc        = b_in_valid && b_in_ready;
            pop        = ((cyc % 2) == 0) && b_rd_valid;
            b_rd_ready = pop;
            if (pop) begin
                if (int'(b_rd_flit) != got) order_err++;
                if (int'(b_rd_ts) <= prev_ts) ts_err++;
                prev_ts = int'(b_rd_ts);
                got++;
            end
            tick();
            if (acc) sent++;
        end
        b_in_valid = 1'b0;
        b_rd_ready = 1'b0;
        check_eq("t4_got", got, 70);
        check_eq("t4_order_err", order_err, 0);
        check_eq("t4_ts_err", ts_err, 0);
        check_eq("t4_drop", b_drop, 0);
        check_eq("t4_cap", b_cap, 70);
        check_eq("t4_level_end", b_level, 0);

        // Limit of 3
        pulse_clear();
        cfg_limit = 16'd3;
        pulse_arm();
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_flit  = 16'h0300 + 16'(i);
            tick();
        end
        check_eq("t5_state_done", a_state, 3);
        check_eq("t5_done_pulse", a_done, 1);
        check_eq("t5_cap", a_cap, 3);
        a_in_flit = 16'h0303;
        tick();
        a_in_valid = 1'b0;
        check_eq("t5_cap_after", a_cap, 3);
        check_eq("t5_level_after", a_level, 3);
        check_eq("t5_pulse_gone", a_done, 0);

        // Stop and arm together while capturing: stop wins
        pulse_clear();
        cfg_limit = '0;
        pulse_arm();
        a_in_valid = 1'b1;
        a_in_flit  = 16'h0400;
        tick();
        a_in_valid = 1'b0;
        check_eq("t6_capturing", a_state, 2);
        ctl_stop = 1'b1;
        ctl_arm  = 1'b1;
        tick();
        ctl_stop = 1'b0;
        ctl_arm  = 1'b0;
        check_eq("t6_state", a_state, 3);
        check_eq("t6_cap", a_cap, 1);
        check_eq("t6_done_pulse", a_done, 1);

        // Clear during capture with 10 entries, concurrent pop ignored
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            a_in_flit  = 16'h0500 + 16'(i);
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("t7_level", a_level, 10);
        check_eq("t7_state", a_state, 2);
        ctl_clear  = 1'b1;
        a_rd_ready = 1'b1;
        tick();
        ctl_clear  = 1'b0;
        a_rd_ready = 1'b0;
        check_eq("t7_level_clr", a_level, 0);
        check_eq("t7_cap_clr", a_cap, 0);
        check_eq("t7_drop_clr", a_drop, 0);
        check_eq("t7_state_clr", a_state, 0);
        check_eq("t7_rd_valid_clr", a_rd_valid, 0);

        // Asynchronous reset mid-capture with 7 entries
        pulse_arm();
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_in_flit  = 16'h0600 + 16'(i);
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("t8_level", a_level, 7);
        rst_n = 1'b0;
        #1;
        check_eq("t8_rd_valid", a_rd_valid, 0);
        check_eq("t8_level_rst", a_level, 0);
        check_eq("t8_state_rst", a_state, 0);
        check_eq("t8_in_ready", a_in_ready, 1);
        check_eq("t8_cap_rst", a_cap, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("t8_level_post", a_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
